wb_stage_pipe: RTL and testbench

- Parametrised, registered writeback stage for the RISC-V core.
- Accepts one retiring instruction per handshake from MEM and selects the writeback source: ALU, load, PC+4, LUI immediate or AUIPC PC+imm.
- For loads it waits a variable number of cycles for the data memory response, then extracts the byte, half or word and sign- or zero-extends it.
- Drives a registered register-file write port, error pulses and a retired-instruction counter.

---
 rtl/wb_stage_pipe.sv | 250 +++++++++++++++++++++++++
 tb/tb_wb_stage_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_pipe.sv
// Writeback stage: accepts one retiring instruction from MEM and selects its
// writeback value. For loads it waits for the data memory response, then
// extracts and extends the addressed byte, half, word or double. The stage
// drives a registered register-file write port, one-cycle error pulses and a
// retired-instruction counter.
module wb_stage_pipe #(
   parameter int XLEN         = 32,
   parameter int LOAD_TIMEOUT = 15,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [XLEN-1:0]  alu_data_i,
   input  logic [XLEN-1:0]  pc_add4_i,
   input  logic [XLEN-1:0]  pc_imm_i,
   input  logic [XLEN-1:0]  imm_i,
   input  logic [4:0]       rd_i,
   input  logic             reg_write_i,
   input  logic [2:0]       wb_sel_i,
   input  logic [2:0]       load_fn_i,
   input  logic             dmem_rvalid_i,
   input  logic [XLEN-1:0]  dmem_rdata_i,
   output logic             rf_we_o,
   output logic [4:0]       rf_waddr_o,
   output logic [XLEN-1:0]  rf_wdata_o,
   output logic             misalign_err_o,
   output logic             load_err_o,
   output logic [CNT_W-1:0] instret_o
);

   localparam int NBYTES = XLEN / 8;
   localparam int OFFW   = $clog2(NBYTES);
   localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

   localparam logic [2:0] SEL_ALU   = 3'd0;
   localparam logic [2:0] SEL_LOAD  = 3'd1;
   localparam logic [2:0] SEL_PC4   = 3'd2;
   localparam logic [2:0] SEL_IMM   = 3'd3;
   localparam logic [2:0] SEL_PCIMM = 3'd4;

   localparam logic [2:0] FN_LB  = 3'b000;
   localparam logic [2:0] FN_LH  = 3'b001;
   localparam logic [2:0] FN_LW  = 3'b010;
   localparam logic [2:0] FN_LD  = 3'b011;
   localparam logic [2:0] FN_LBU = 3'b100;
   localparam logic [2:0] FN_LHU = 3'b101;
   localparam logic [2:0] FN_LWU = 3'b110;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [7:0]        tmo_cnt_reg, tmo_cnt_next;

   // Fields of the accepted instruction still needed while a load is waiting
   logic [4:0]        rd_hold_reg;
   logic              rw_hold_reg;
   logic [2:0]        fn_hold_reg;
   logic [OFFW-1:0]   off_hold_reg;

   logic              rf_we_reg;
   logic [4:0]        rf_waddr_reg;
   logic [XLEN-1:0]   rf_wdata_reg;
   logic              mis_err_reg;
   logic              ld_err_reg;
   logic [CNT_W-1:0]  instret_reg;

   logic              accept;
   logic [OFFW-1:0]   off_in;
   logic              load_bad;
   logic              acc_err;
   logic [XLEN-1:0]   src_data;
   logic [XLEN-1:0]   load_ext;
   logic              commit_ok;
   logic [XLEN-1:0]   commit_data;
   logic [4:0]        commit_rd;
   logic              commit_rw;
   logic              mis_next;
   logic              ld_err_next;

   assign in_ready_o = (state_reg == IDLE);
   assign accept     = in_valid_i && in_ready_o;
   assign off_in     = alu_data_i[OFFW-1:0];

   // Lane views of the memory word, indexed by the byte offset of the load
   logic [7:0]  byte_lane [NBYTES];
   logic [15:0] half_lane [NBYTES/2];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] word_sel;

   genvar gi;
   generate
      for (gi = 0; gi < NBYTES; gi++) begin : g_byte
         assign byte_lane[gi] = dmem_rdata_i[gi*8 +: 8];
      end
      for (gi = 0; gi < NBYTES/2; gi++) begin : g_half
         assign half_lane[gi] = dmem_rdata_i[gi*16 +: 16];
      end
      if (XLEN == 64) begin : g_word64
         assign word_sel = off_hold_reg[OFFW-1] ? dmem_rdata_i[XLEN-1 -: 32]
                                                : dmem_rdata_i[31:0];
      end else begin : g_word32
         assign word_sel = dmem_rdata_i[31:0];
      end
   endgenerate

   assign byte_sel = byte_lane[off_hold_reg];
   assign half_sel = half_lane[off_hold_reg[OFFW-1:1]];

   // Alignment and legality check of a load at acceptance time
   always_comb begin
      load_bad = 1'b0;
      case (load_fn_i)
         FN_LB, FN_LBU: load_bad = 1'b0;
         FN_LH, FN_LHU: load_bad = off_in[0];
         FN_LW:         load_bad = (off_in[1:0] != 2'b00);
         FN_LWU:        load_bad = (off_in[1:0] != 2'b00) || (XLEN == 32);
         FN_LD:         load_bad = (off_in != '0) || (XLEN == 32);
         default:       load_bad = 1'b1;
      endcase
      acc_err = (wb_sel_i > SEL_PCIMM) || ((wb_sel_i == SEL_LOAD) && load_bad);
   end

   // Writeback source for non-load instructions
   always_comb begin
      src_data = alu_data_i;
      case (wb_sel_i)
         SEL_ALU:   src_data = alu_data_i;
         SEL_PC4:   src_data = pc_add4_i;
         SEL_IMM:   src_data = imm_i;
         SEL_PCIMM: src_data = pc_imm_i;
         default:   src_data = alu_data_i;
      endcase
   end

   // Sign- or zero-extension of the selected load lane
   always_comb begin
      load_ext = '0;
      case (fn_hold_reg)
         FN_LB:   load_ext = XLEN'($signed(byte_sel));
         FN_LH:   load_ext = XLEN'($signed(half_sel));
         FN_LW:   load_ext = XLEN'($signed(word_sel));
         FN_LD:   load_ext = dmem_rdata_i;
         FN_LBU:  load_ext = XLEN'(byte_sel);
         FN_LHU:  load_ext = XLEN'(half_sel);
         FN_LWU:  load_ext = XLEN'(word_sel);
         default: load_ext = '0;
      endcase
   end

   // Next-state logic and the values to be registered on entry to COMMIT
   always_comb begin
      state_next   = state_reg;
      tmo_cnt_next = tmo_cnt_reg;
      commit_ok    = 1'b0;
      commit_data  = '0;
      commit_rd    = rd_hold_reg;
      commit_rw    = rw_hold_reg;
      mis_next     = 1'b0;
      ld_err_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_valid_i) begin
               if (acc_err) begin
                  state_next = COMMIT;
                  mis_next   = 1'b1;
               end else if (wb_sel_i == SEL_LOAD) begin
                  state_next   = WAIT;
                  tmo_cnt_next = '0;
               end else begin
                  state_next  = COMMIT;
                  commit_ok   = 1'b1;
                  commit_data = src_data;
                  commit_rd   = rd_i;
                  commit_rw   = reg_write_i;
               end
            end
         end
         WAIT: begin
            // Data arriving on the last allowed cycle still wins over the timeout
            if (dmem_rvalid_i) begin
               state_next  = COMMIT;
               commit_ok   = 1'b1;
               commit_data = load_ext;
            end else if (tmo_cnt_reg == TMO_LAST) begin
               state_next  = COMMIT;
               ld_err_next = 1'b1;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 8'd1;
            end
         end
         COMMIT: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, timeout counter and registered writeback outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         tmo_cnt_reg  <= '0;
         rf_we_reg    <= 1'b0;
         rf_waddr_reg <= '0;
         rf_wdata_reg <= '0;
         mis_err_reg  <= 1'b0;
         ld_err_reg   <= 1'b0;
         instret_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         tmo_cnt_reg <= tmo_cnt_next;
         rf_we_reg   <= commit_ok && commit_rw && (commit_rd != 5'd0);
         mis_err_reg <= mis_next;
         ld_err_reg  <= ld_err_next;
         if (commit_ok) begin
            rf_waddr_reg <= commit_rd;
            rf_wdata_reg <= commit_data;
            instret_reg  <= instret_reg + CNT_W'(1);
         end
      end
   end

   // Holding registers loaded on every accepted instruction
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_hold_reg  <= '0;
         rw_hold_reg  <= 1'b0;
         fn_hold_reg  <= '0;
         off_hold_reg <= '0;
      end else if (accept) begin
         rd_hold_reg  <= rd_i;
         rw_hold_reg  <= reg_write_i;
         fn_hold_reg  <= load_fn_i;
         off_hold_reg <= off_in;
      end
   end

   assign rf_we_o        = rf_we_reg;
   assign rf_waddr_o     = rf_waddr_reg;
   assign rf_wdata_o     = rf_wdata_reg;
   assign misalign_err_o = mis_err_reg;
   assign load_err_o     = ld_err_reg;
   assign instret_o      = instret_reg;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: a 32-bit instance (timeout 15, 32-bit counter)
// and a 64-bit instance (timeout 4, 4-bit counter) share stimulus buses;
// only the selected instance sees in_valid. Expected values come from a
// behavioural model of the writeback rules.
module tb_wb_stage_pipe;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid;
   logic        cur64;
   logic [63:0] d_alu, d_pc4, d_pcimm, d_imm, d_rdata;
   logic [4:0]  d_rd;
   logic        d_rw;
   logic [2:0]  d_sel, d_fn;
   logic        d_rvalid;

   logic        v32, v64;
   assign v32 = in_valid && !cur64;
   assign v64 = in_valid && cur64;

   logic        r32, we32, me32, le32;
   logic [4:0]  wa32;
   logic [31:0] wd32, ic32;
   logic        r64, we64, me64, le64;
   logic [4:0]  wa64;
   logic [63:0] wd64;
   logic [3:0]  ic64;

   wb_stage_pipe #(.XLEN(32), .LOAD_TIMEOUT(15), .CNT_W(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(v32), .in_ready_o(r32),
      .alu_data_i(d_alu[31:0]), .pc_add4_i(d_pc4[31:0]), .pc_imm_i(d_pcimm[31:0]),
      .imm_i(d_imm[31:0]), .rd_i(d_rd), .reg_write_i(d_rw), .wb_sel_i(d_sel),
      .load_fn_i(d_fn), .dmem_rvalid_i(d_rvalid), .dmem_rdata_i(d_rdata[31:0]),
      .rf_we_o(we32), .rf_waddr_o(wa32), .rf_wdata_o(wd32),
      .misalign_err_o(me32), .load_err_o(le32), .instret_o(ic32)
   );

   wb_stage_pipe #(.XLEN(64), .LOAD_TIMEOUT(4), .CNT_W(4)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(v64), .in_ready_o(r64),
      .alu_data_i(d_alu), .pc_add4_i(d_pc4), .pc_imm_i(d_pcimm),
      .imm_i(d_imm), .rd_i(d_rd), .reg_write_i(d_rw), .wb_sel_i(d_sel),
      .load_fn_i(d_fn), .dmem_rvalid_i(d_rvalid), .dmem_rdata_i(d_rdata),
      .rf_we_o(we64), .rf_waddr_o(wa64), .rf_wdata_o(wd64),
      .misalign_err_o(me64), .load_err_o(le64), .instret_o(ic64)
   );

   // Observed outputs of the currently selected instance
   logic        o_ready, o_we, o_mis, o_lerr;
   logic [4:0]  o_waddr;
   logic [63:0] o_wdata, o_instret;
   assign o_ready   = cur64 ? r64  : r32;
   assign o_we      = cur64 ? we64 : we32;
   assign o_mis     = cur64 ? me64 : me32;
   assign o_lerr    = cur64 ? le64 : le32;
   assign o_waddr   = cur64 ? wa64 : wa32;
   assign o_wdata   = cur64 ? wd64 : {32'd0, wd32};
   assign o_instret = cur64 ? {60'd0, ic64} : {32'd0, ic32};

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_ret [2];
   logic [63:0] last_wdata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: kind 0 = plain commit, 1 = load that waits, 2 = misaligned/illegal
   function automatic void model(input bit is64, input logic [2:0] sel, input logic [2:0] fn,
                                 input logic [63:0] alu, input logic [63:0] rdata,
                                 input logic [63:0] pc4, input logic [63:0] pcimm,
                                 input logic [63:0] imm, output int kind,
                                 output logic [63:0] data);
      int          nb, off, size;
      logic [63:0] xmask, mask, v;
      nb    = is64 ? 8 : 4;
      off   = int'(alu[2:0]) % nb;
      xmask = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      kind  = 0;
      data  = 64'd0;
      case (sel)
         3'd0: data = alu & xmask;
         3'd2: data = pc4 & xmask;
         3'd3: data = imm & xmask;
         3'd4: data = pcimm & xmask;
         3'd1: begin
            size = 1 << fn[1:0];
            if (fn == 3'd7 || (!is64 && (fn == 3'd3 || fn == 3'd6)))
               kind = 2;
            else if (off % size != 0)
               kind = 2;
            else begin
               kind = 1;
               mask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (size * 8)) - 64'd1);
               v    = (rdata >> (off * 8)) & mask;
               if (!fn[2] && v[size*8-1]) v = v | ~mask;
               data = v & xmask;
            end
         end
         default: kind = 2;
      endcase
   endfunction

   // One instruction from acceptance to the return to IDLE; lat = wait cycle
   // carrying rvalid (0 or beyond the timeout means no response in time)
   task automatic run_txn(input bit is64, input logic [2:0] sel, input logic [2:0] fn,
                          input logic [4:0] rd, input logic rw, input logic [63:0] alu,
                          input logic [63:0] pc4, input logic [63:0] pcimm,
                          input logic [63:0] imm, input logic [63:0] rdata, input int lat);
      int          kind, tmo, idx;
      logic [63:0] data, cmask;
      bit          exp_we, done;
      cur64 = is64;
      idx   = is64 ? 1 : 0;
      tmo   = is64 ? 4 : 15;
      cmask = is64 ? 64'hF : 64'hFFFF_FFFF;
      model(is64, sel, fn, alu, rdata, pc4, pcimm, imm, kind, data);
      exp_we = rw && (rd != 5'd0);
      #1;
      chk("ready_idle", {63'd0, o_ready}, 64'd1);
      d_alu = alu; d_pc4 = pc4; d_pcimm = pcimm; d_imm = imm;
      d_rd = rd; d_rw = rw; d_sel = sel; d_fn = fn;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      d_alu = {$urandom, $urandom}; d_rd = 5'($urandom); d_fn = 3'($urandom);
      d_rw = 1'($urandom);
      if (kind == 2) begin
         chk("mis_err", {63'd0, o_mis}, 64'd1);
         chk("mis_we", {63'd0, o_we}, 64'd0);
         chk("mis_ready", {63'd0, o_ready}, 64'd0);
         chk("mis_instret", o_instret, exp_ret[idx] & cmask);
      end else if (kind == 0) begin
         exp_ret[idx] = exp_ret[idx] + 64'd1;
         chk("op_we", {63'd0, o_we}, {63'd0, exp_we});
         if (exp_we) begin
            chk("op_waddr", {59'd0, o_waddr}, {59'd0, rd});
            chk("op_wdata", o_wdata, data);
         end
         chk("op_mis", {63'd0, o_mis}, 64'd0);
         chk("op_instret", o_instret, exp_ret[idx] & cmask);
      end else begin
         done = 1'b0;
         for (int c = 1; c <= tmo && !done; c++) begin
            chk("wait_ready", {63'd0, o_ready}, 64'd0);
            chk("wait_lerr", {63'd0, o_lerr}, 64'd0);
            d_rvalid = (c == lat);
            d_rdata  = (c == lat) ? rdata : {$urandom, $urandom};
            @(posedge clk); #1;
            d_rvalid = 1'b0;
            if (c == lat) begin
               done = 1'b1;
               exp_ret[idx] = exp_ret[idx] + 64'd1;
               chk("ld_we", {63'd0, o_we}, {63'd0, exp_we});
               if (exp_we) begin
                  chk("ld_waddr", {59'd0, o_waddr}, {59'd0, rd});
                  chk("ld_wdata", o_wdata, data);
               end
               chk("ld_lerr", {63'd0, o_lerr}, 64'd0);
               chk("ld_instret", o_instret, exp_ret[idx] & cmask);
            end else if (c == tmo) begin
               chk("tmo_lerr", {63'd0, o_lerr}, 64'd1);
               chk("tmo_we", {63'd0, o_we}, 64'd0);
               chk("tmo_instret", o_instret, exp_ret[idx] & cmask);
            end
         end
      end
      last_wdata = o_wdata;
      @(posedge clk); #1;
      chk("post_we", {63'd0, o_we}, 64'd0);
      chk("post_mis", {63'd0, o_mis}, 64'd0);
      chk("post_lerr", {63'd0, o_lerr}, 64'd0);
      chk("post_ready", {63'd0, o_ready}, 64'd1);
      $display("[TB] txn x%0d sel=%0d fn=%0d rd=%0d addr=%0h lat=%0d kind=%0d exp=%0h",
               is64 ? 64 : 32, sel, fn, rd, alu, lat, kind, data);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] rsel;
      int         rlat;
      rst_n = 1'b0; in_valid = 1'b0; cur64 = 1'b0; d_rvalid = 1'b0;
      d_alu = '0; d_pc4 = '0; d_pcimm = '0; d_imm = '0; d_rdata = '0;
      d_rd = '0; d_rw = 1'b0; d_sel = '0; d_fn = '0;
      exp_ret[0] = 64'd0; exp_ret[1] = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         cur64 = (k == 1);
         #1;
         chk("rst_we", {63'd0, o_we}, 64'd0);
         chk("rst_waddr", {59'd0, o_waddr}, 64'd0);
         chk("rst_wdata", o_wdata, 64'd0);
         chk("rst_mis", {63'd0, o_mis}, 64'd0);
         chk("rst_lerr", {63'd0, o_lerr}, 64'd0);
         chk("rst_instret", o_instret, 64'd0);
         chk("rst_ready", {63'd0, o_ready}, 64'd1);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ALU op
      run_txn(0, 3'd0, 3'd0, 5'd5, 1'b1, 64'h1234, 64'h4, 64'h8, 64'hC, 64'h0, 0);
      chk("alu_const", last_wdata, 64'h0000_1234);
      chk("alu_waddr_hold", {59'd0, o_waddr}, 64'd5);
      // Byte/half loads, memory latency 3
      run_txn(0, 3'd1, 3'b000, 5'd7, 1'b1, 64'h1003, 0, 0, 0, 64'h80FF_7F01, 3);
      chk("lb_const", last_wdata, 64'hFFFF_FF80);
      run_txn(0, 3'd1, 3'b100, 5'd7, 1'b1, 64'h1003, 0, 0, 0, 64'h80FF_7F01, 3);
      chk("lbu_const", last_wdata, 64'h0000_0080);
      run_txn(0, 3'd1, 3'b001, 5'd8, 1'b1, 64'h1002, 0, 0, 0, 64'h80FF_7F01, 3);
      chk("lh_const", last_wdata, 64'hFFFF_80FF);
      // Misaligned word
      run_txn(0, 3'd1, 3'b010, 5'd9, 1'b1, 64'h1002, 0, 0, 0, 64'h1111_2222, 1);
      // Timeout, then rvalid on the final wait cycle
      run_txn(0, 3'd1, 3'b010, 5'd10, 1'b1, 64'h1000, 0, 0, 0, 64'h5555_AAAA, 0);
      run_txn(0, 3'd1, 3'b010, 5'd10, 1'b1, 64'h1000, 0, 0, 0, 64'h5555_AAAA, 15);
      chk("lw_last_cycle", last_wdata, 64'h5555_AAAA);
      // AUIPC to x0, LUI to x1
      run_txn(0, 3'd4, 3'd0, 5'd0, 1'b1, 64'h0, 64'h0, 64'h100, 64'h0, 64'h0, 0);
      run_txn(0, 3'd3, 3'd0, 5'd1, 1'b1, 64'h0, 64'h0, 64'h0, 64'hABCD_E000, 64'h0, 0);
      chk("lui_const", last_wdata, 64'hABCD_E000);
      // Illegal selector and LD on the 32-bit instance
      run_txn(0, 3'd6, 3'd0, 5'd3, 1'b1, 64'h0, 0, 0, 0, 0, 0);
      run_txn(0, 3'd1, 3'b011, 5'd3, 1'b1, 64'h2000, 0, 0, 0, 0, 1);

      // Reset while waiting for a load
      cur64 = 1'b0;
      d_sel = 3'd1; d_fn = 3'b010; d_alu = 64'h0; d_rd = 5'd4; d_rw = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      exp_ret[0] = 64'd0; exp_ret[1] = 64'd0;
      chk("rstw_ready", {63'd0, o_ready}, 64'd1);
      chk("rstw_we", {63'd0, o_we}, 64'd0);
      chk("rstw_instret", o_instret, 64'd0);
      rst_n = 1'b1; d_rvalid = 1'b1; d_rdata = 64'hDEAD_BEEF;
      @(posedge clk); #1;
      d_rvalid = 1'b0;
      chk("rstw_late_we", {63'd0, o_we}, 64'd0);
      chk("rstw_late_ready", {63'd0, o_ready}, 64'd1);
      $display("[TB] txn x32 reset during WAIT");

      // 64-bit instance: LD, LWU, LW, misaligned LD
      run_txn(1, 3'd1, 3'b011, 5'd2, 1'b1, 64'h2000, 0, 0, 0, 64'h1122_3344_5566_7788, 2);
      chk("ld_const", last_wdata, 64'h1122_3344_5566_7788);
      run_txn(1, 3'd1, 3'b110, 5'd2, 1'b1, 64'h2000, 0, 0, 0, 64'h0000_0000_8000_0000, 1);
      chk("lwu_const", last_wdata, 64'h0000_0000_8000_0000);
      run_txn(1, 3'd1, 3'b010, 5'd2, 1'b1, 64'h2004, 0, 0, 0, 64'h8000_0000_0000_0000, 1);
      run_txn(1, 3'd1, 3'b011, 5'd2, 1'b1, 64'h2004, 0, 0, 0, 64'h0, 1);
      // Counter wrap on the 4-bit instance
      for (int i = 0; i < 18; i++)
         run_txn(1, 3'd0, 3'd0, 5'(i), 1'b1, {$urandom, $urandom}, 0, 0, 0, 0, 0);

      // Randomised traffic on both instances
      for (int i = 0; i < 80; i++) begin
         rsel = ($urandom_range(0, 9) < 5) ? 3'd1 : 3'($urandom_range(0, 7));
         rlat = $urandom_range(0, (i % 2) ? 6 : 17);
         run_txn(i % 2 == 1, rsel, 3'($urandom_range(0, 7)), 5'($urandom),
                 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, rlat);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
